// File: rtl/burst_ram.sv
// -----------------------------------------------------------------------------
// burst_ram
//   Single-port word memory driven by burst commands. A command is accepted
//   only in IDLE. The four commands are:
//     - write burst: len+1 beats taken over a valid/ready handshake.
//     - read burst: len+1 beats delivered over a valid/ready handshake.
//     - clear: len+1 consecutive words are zeroed, one word per cycle.
//     - reserved: rejected with an err pulse.
//   Burst addresses wrap modulo the memory depth. Reset never touches the
//   memory array.
//
// Ports
//   clk_i        : clock, rising edge
//   rst_ni       : asynchronous active-low reset
//   start_i      : command strobe (sampled in IDLE only)
//   mode_i       : 00 read, 01 write, 10 clear, 11 reserved
//   base_addr_i  : first word address of the burst
//   len_i        : beats minus one
//   busy_o       : high whenever a command is in progress
//   done_o       : one-cycle pulse on command completion
//   err_o        : one-cycle pulse on a rejected command
//   wr_data_i    : write beat data
//   wr_valid_i   : write beat offered
//   wr_ready_o   : write beat can be accepted
//   rd_data_o    : read beat data (held while stalled)
//   rd_valid_o   : read beat present
//   rd_ready_i   : read beat consumed
// -----------------------------------------------------------------------------
module burst_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 15,
  parameter int LEN_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  input  logic              rd_ready_i
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] MODE_READ  = 2'b00;
  localparam logic [1:0] MODE_WRITE = 2'b01;
  localparam logic [1:0] MODE_CLEAR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_CLEAR = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;        // next word to write / read / clear
  logic [LEN_W-1:0]    beat_q, beat_d;        // beats left to complete, minus one
  logic [LEN_W-1:0]    iss_q, iss_d;          // memory reads left to issue, minus one
  logic                iss_more_q, iss_more_d;
  logic                mem_vld_q, mem_vld_d;  // mem_rd_q holds a beat not yet forwarded
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                wr_ready_q, wr_ready_d;

  logic [DATA_W-1:0]   mem [0:DEPTH-1];
  logic [DATA_W-1:0]   mem_rd_q;
  logic                mem_we_s;
  logic                mem_re_s;
  logic [DATA_W-1:0]   mem_wdata_s;
  logic                adv_s;
  logic                rd_take_s;

  // Next-state, datapath control and output-register next values.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    beat_d      = beat_q;
    iss_d       = iss_q;
    iss_more_d  = iss_more_q;
    mem_vld_d   = mem_vld_q;
    rd_valid_d  = rd_valid_q;
    rd_data_d   = rd_data_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    mem_we_s    = 1'b0;
    mem_re_s    = 1'b0;
    mem_wdata_s = {DATA_W{1'b0}};
    // The read pipeline may advance when the output register is empty or is
    // being drained this cycle; both stages then move together.
    adv_s       = (!rd_valid_q) || rd_ready_i;
    rd_take_s   = rd_valid_q && rd_ready_i;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d     = base_addr_i;
          beat_d     = len_i;
          iss_d      = len_i;
          iss_more_d = 1'b0;
          case (mode_i)
            MODE_READ: begin
              state_d    = S_READ;
              iss_more_d = 1'b1;
            end
            MODE_WRITE: state_d = S_WRITE;
            MODE_CLEAR: state_d = S_CLEAR;
            default: begin
              state_d = S_IDLE;
              addr_d  = addr_q;
              beat_d  = beat_q;
              iss_d   = iss_q;
              err_d   = 1'b1;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WRITE: begin
        if (wr_valid_i && wr_ready_q) begin
          mem_we_s    = 1'b1;
          mem_wdata_s = wr_data_i;
          addr_d      = addr_q + ADDR_W'(1);
          if (beat_q == {LEN_W{1'b0}}) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            beat_d = beat_q - LEN_W'(1);
          end
        end else begin
          state_d = S_WRITE;
        end
      end

      S_CLEAR: begin
        mem_we_s    = 1'b1;
        mem_wdata_s = {DATA_W{1'b0}};
        addr_d      = addr_q + ADDR_W'(1);
        if (beat_q == {LEN_W{1'b0}}) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          beat_d = beat_q - LEN_W'(1);
        end
      end

      S_READ: begin
        if (adv_s) begin
          rd_valid_d = mem_vld_q;
          rd_data_d  = mem_vld_q ? mem_rd_q : rd_data_q;
          mem_re_s   = iss_more_q;
          mem_vld_d  = iss_more_q;
          if (iss_more_q) begin
            addr_d = addr_q + ADDR_W'(1);
            if (iss_q == {LEN_W{1'b0}}) begin
              iss_more_d = 1'b0;
            end else begin
              iss_d = iss_q - LEN_W'(1);
            end
          end else begin
            iss_more_d = 1'b0;
          end
        end else begin
          rd_valid_d = rd_valid_q;
        end
        // Completion is tied to consumption of the final beat, not to issue.
        if (rd_take_s) begin
          if (beat_q == {LEN_W{1'b0}}) begin
            state_d    = S_IDLE;
            done_d     = 1'b1;
            rd_valid_d = 1'b0;
            mem_vld_d  = 1'b0;
            iss_more_d = 1'b0;
          end else begin
            beat_d = beat_q - LEN_W'(1);
          end
        end else begin
          beat_d = beat_q;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d     = (state_d != S_IDLE);
    wr_ready_d = (state_d == S_WRITE);
  end

  // Control state and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      addr_q     <= {ADDR_W{1'b0}};
      beat_q     <= {LEN_W{1'b0}};
      iss_q      <= {LEN_W{1'b0}};
      iss_more_q <= 1'b0;
      mem_vld_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= {DATA_W{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beat_q     <= beat_d;
      iss_q      <= iss_d;
      iss_more_q <= iss_more_d;
      mem_vld_q  <= mem_vld_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  // Memory array with synchronous read; deliberately outside reset so that
  // contents survive rst_ni.
  always_ff @(posedge clk_i) begin
    if (mem_we_s) begin
      mem[addr_q] <= mem_wdata_s;
    end
    if (mem_re_s) begin
      mem_rd_q <= mem[addr_q];
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign wr_ready_o = wr_ready_q;
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: tb/tb_burst_ram.sv
module tb_burst_ram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic [14:0] base_addr;
  logic [7:0]  len;
  logic        busy, done, err;
  logic [7:0]  wr_data;
  logic        wr_valid, wr_ready;
  logic [7:0]  rd_data;
  logic        rd_valid, rd_ready;

  always #5 clk = ~clk;

  burst_ram #(.DATA_W(8), .ADDR_W(15), .LEN_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode),
    .base_addr_i(base_addr), .len_i(len), .busy_o(busy), .done_o(done),
    .err_o(err), .wr_data_i(wr_data), .wr_valid_i(wr_valid),
    .wr_ready_o(wr_ready), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .rd_ready_i(rd_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] model [int];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] wbuf[$];

  int   wr_cycles, wr_dones, wr_errs;
  int   rd_cycles, rd_dones, first_valid, stall_bad;
  logic rd_valid_after, busy_after;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] m, input logic [14:0] b, input logic [7:0] l);
    start = 1'b1; mode = m; base_addr = b; len = l;
    tick();
    start = 1'b0;
  endtask

  // Write burst with wr_valid held high; model updated as beats are accepted.
  task automatic do_write(input logic [14:0] b, input logic [7:0] l, input bit poke);
    int idx;
    logic acc;
    logic [14:0] a;
    wr_cycles = 0; wr_dones = 0; wr_errs = 0; idx = 0;
    send_cmd(2'b01, b, l);
    wr_valid = 1'b1;
    wr_data  = wbuf[0];
    while (idx <= int'(l) && wr_cycles < 1000) begin
      acc = wr_ready;
      if (poke && idx == 1) begin
        start = 1'b1; mode = 2'b11; base_addr = 15'h0000; len = 8'd0;
      end else begin
        start = 1'b0;
      end
      tick();
      wr_cycles++;
      if (done) wr_dones++;
      if (err) wr_errs++;
      if (acc) begin
        a = b + 15'(idx);
        model[int'(a)] = wbuf[idx];
        idx++;
        if (idx <= int'(l)) wr_data = wbuf[idx];
      end
    end
    start = 1'b0;
    wr_valid = 1'b0;
    tick();
    if (done) wr_dones++;
    if (err) wr_errs++;
  endtask

  // Read burst; expected beats pushed to exp_q, received beats collected in got_q.
  // pat 0: rd_ready always high; pat 1: rd_ready 1,0,0,1,0,0,...
  task automatic do_read(input logic [14:0] b, input logic [7:0] l, input int pat);
    int k;
    logic [7:0] held;
    logic was_stall;
    logic [14:0] a;
    got_q.delete();
    stall_bad = 0; rd_cycles = 0; rd_dones = 0; first_valid = -1; k = 0;
    for (int i = 0; i <= int'(l); i++) begin
      a = b + 15'(i);
      exp_q.push_back(model[int'(a)]);
    end
    send_cmd(2'b00, b, l);
    while (got_q.size() < int'(l) + 1 && rd_cycles < 2000) begin
      rd_ready = (pat == 0) ? 1'b1 : ((k % 3) == 0);
      k++;
      if (rd_valid && first_valid < 0) first_valid = rd_cycles;
      was_stall = rd_valid && !rd_ready;
      held = rd_data;
      if (rd_valid && rd_ready) got_q.push_back(rd_data);
      tick();
      rd_cycles++;
      if (done) rd_dones++;
      if (was_stall && (!rd_valid || rd_data !== held)) stall_bad++;
    end
    rd_ready = 1'b0;
    rd_valid_after = rd_valid;
    busy_after = busy;
    tick();
    if (done) rd_dones++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; mode = 2'b00; base_addr = 15'h0; len = 8'h0;
    wr_data = 8'h00; wr_valid = 1'b0; rd_ready = 1'b0;
    repeat (3) tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready: got %b expected 0", wr_ready); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 00", rd_data); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    logic [7:0] e;
    wbuf = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    do_write(15'h0010, 8'd3, 1'b0);
    n_checks++; if (wr_cycles != 4) begin n_fail++; $display("FAIL wr_cycles: got %0d expected 4", wr_cycles); end
    n_checks++; if (wr_dones != 1) begin n_fail++; $display("FAIL wr_done_count: got %0d expected 1", wr_dones); end
    do_read(15'h0010, 8'd3, 0);
    n_checks++; if (first_valid != 2) begin n_fail++; $display("FAIL rd_latency: got %0d expected 2", first_valid); end
    n_checks++; if (rd_cycles != 6) begin n_fail++; $display("FAIL rd_no_bubble: got %0d cycles expected 6", rd_cycles); end
    n_checks++; if (rd_dones != 1) begin n_fail++; $display("FAIL rd_done_count: got %0d expected 1", rd_dones); end
    n_checks++; if (rd_valid_after !== 1'b0 || busy_after !== 1'b0) begin n_fail++; $display("FAIL rd_end_state: got valid=%b busy=%b expected 0 0", rd_valid_after, busy_after); end
    n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL rd_count: got %0d expected 4", got_q.size()); end
    foreach (got_q[i]) begin
      e = exp_q.pop_front();
      n_checks++; if (got_q[i] !== e) begin n_fail++; $display("FAIL basic_beat%0d: got %h expected %h", i, got_q[i], e); end
    end
    exp_q.delete();
  endtask

  task automatic test_wrap();
    logic [7:0] e;
    wbuf = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_write(15'h7FFE, 8'd3, 1'b0);
    n_checks++; if (wr_dones != 1) begin n_fail++; $display("FAIL wrap_wr_done: got %0d expected 1", wr_dones); end
    do_read(15'h7FFE, 8'd3, 0);
    n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL wrap_count: got %0d expected 4", got_q.size()); end
    foreach (got_q[i]) begin
      e = exp_q.pop_front();
      n_checks++; if (got_q[i] !== e) begin n_fail++; $display("FAIL wrap_beat%0d: got %h expected %h", i, got_q[i], e); end
    end
    exp_q.delete();
    // Low words read directly must hold the wrapped beats.
    do_read(15'h0000, 8'd1, 0);
    n_checks++; if (got_q.size() != 2 || got_q[0] !== 8'h33 || got_q[1] !== 8'h44) begin
      n_fail++; $display("FAIL wrap_low_words: got %p expected 33 44", got_q);
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic [7:0] e;
    wbuf = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58};
    do_write(15'h0200, 8'd7, 1'b0);
    do_read(15'h0200, 8'd7, 1);
    n_checks++; if (stall_bad != 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable stalls expected 0", stall_bad); end
    n_checks++; if (rd_dones != 1) begin n_fail++; $display("FAIL bp_done: got %0d expected 1", rd_dones); end
    n_checks++; if (got_q.size() != 8) begin n_fail++; $display("FAIL bp_count: got %0d expected 8", got_q.size()); end
    foreach (got_q[i]) begin
      e = exp_q.pop_front();
      n_checks++; if (got_q[i] !== e) begin n_fail++; $display("FAIL bp_beat%0d: got %h expected %h", i, got_q[i], e); end
    end
    exp_q.delete();
  endtask

  task automatic test_clear();
    int cyc, got_done, bad;
    logic [7:0] e;
    wbuf.delete();
    for (int i = 0; i < 16; i++) wbuf.push_back(8'hFF);
    do_write(15'h0100, 8'd15, 1'b0);
    send_cmd(2'b10, 15'h0104, 8'd3);
    cyc = 0; got_done = -1; bad = 0;
    while (got_done < 0 && cyc < 50) begin
      if (wr_ready || rd_valid) bad++;
      tick();
      cyc++;
      if (done) got_done = cyc;
    end
    for (int i = 4; i < 8; i++) model[32'h100 + i] = 8'h00;
    n_checks++; if (got_done != 4) begin n_fail++; $display("FAIL clear_done_time: got %0d expected 4", got_done); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL clear_handshake_low: got %0d expected 0", bad); end
    tick();
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL clear_end: got busy=%b done=%b expected 0 0", busy, done); end
    do_read(15'h0100, 8'd15, 0);
    n_checks++; if (got_q.size() != 16) begin n_fail++; $display("FAIL clear_count: got %0d expected 16", got_q.size()); end
    foreach (got_q[i]) begin
      e = exp_q.pop_front();
      n_checks++; if (got_q[i] !== e) begin n_fail++; $display("FAIL clear_word%0d: got %h expected %h", i, got_q[i], e); end
    end
    exp_q.delete();
  endtask

  task automatic test_cmd_rules();
    logic [7:0] e;
    send_cmd(2'b11, 15'h0000, 8'd0);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL reserved_err: got %b expected 1", err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reserved_busy: got %b expected 0", busy); end
    tick();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reserved_err_pulse: got %b expected 0", err); end
    // start (with altered base/len) during a write burst must be ignored.
    wbuf = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    do_write(15'h0400, 8'd3, 1'b1);
    n_checks++; if (wr_cycles != 4 || wr_dones != 1) begin n_fail++; $display("FAIL busy_start: got cycles=%0d dones=%0d expected 4 1", wr_cycles, wr_dones); end
    n_checks++; if (wr_errs != 0) begin n_fail++; $display("FAIL busy_start_err: got %0d expected 0", wr_errs); end
    do_read(15'h0400, 8'd3, 0);
    n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL busy_start_count: got %0d expected 4", got_q.size()); end
    foreach (got_q[i]) begin
      e = exp_q.pop_front();
      n_checks++; if (got_q[i] !== e) begin n_fail++; $display("FAIL busy_start_beat%0d: got %h expected %h", i, got_q[i], e); end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_burst();
    int dones;
    logic [7:0] e;
    dones = 0;
    send_cmd(2'b01, 15'h0300, 8'd5);
    wr_valid = 1'b1; wr_data = 8'hB1;
    tick();
    if (done) dones++;
    wr_data = 8'hB2;
    tick();
    if (done) dones++;
    model[32'h300] = 8'hB1;
    model[32'h301] = 8'hB2;
    wr_data = 8'hB3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_wr_ready: got %b expected 0", wr_ready); end
    repeat (2) begin tick(); if (done) dones++; end
    wr_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) begin tick(); if (done) dones++; end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d expected 0", dones); end
    do_read(15'h0300, 8'd1, 0);
    n_checks++; if (got_q.size() != 2) begin n_fail++; $display("FAIL rst_mid_count: got %0d expected 2", got_q.size()); end
    foreach (got_q[i]) begin
      e = exp_q.pop_front();
      n_checks++; if (got_q[i] !== e) begin n_fail++; $display("FAIL rst_mid_beat%0d: got %h expected %h", i, got_q[i], e); end
    end
    exp_q.delete();
    // Memory written before the reset is untouched by it.
    do_read(15'h0010, 8'd3, 0);
    foreach (got_q[i]) begin
      e = exp_q.pop_front();
      n_checks++; if (got_q[i] !== e) begin n_fail++; $display("FAIL rst_keep_beat%0d: got %h expected %h", i, got_q[i], e); end
    end
    n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL rst_keep_count: got %0d expected 4", got_q.size()); end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wrap();
    test_backpressure();
    test_clear();
    test_cmd_rules();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/burst_ram.md
BURST_RAM -- requirements
Module: burst_ram

Interface
REQ-001 Parameter DATA_W, default 8: word width in bits.
REQ-002 Parameter ADDR_W, default 15: address width; memory depth SHALL be 2**ADDR_W words.
REQ-003 Parameter LEN_W, default 8: burst-length field width; burst length SHALL be len+1 beats (1..2**LEN_W).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  command strobe, sampled in IDLE only.
REQ-007 mode  input  2  command: 00 read burst, 01 write burst, 10 clear, 11 reserved.
REQ-008 base_addr  input  ADDR_W  first word address of burst.
REQ-009 len  input  LEN_W  beats minus one.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 done  output  1  one-cycle pulse on command completion.
REQ-012 err  output  1  one-cycle pulse on rejected command.
REQ-013 wr_data  input  DATA_W  write beat data.
REQ-014 wr_valid  input  1  write beat offered.
REQ-015 wr_ready  output  1  write beat accepted when wr_valid and wr_ready both high.
REQ-016 rd_data  output  DATA_W  read beat data, held stable while rd_valid and not rd_ready.
REQ-017 rd_valid  output  1  read beat present.
REQ-018 rd_ready  input  1  read beat consumed when rd_valid and rd_ready both high.

Function
REQ-019 States SHALL be IDLE, WRITE, READ, CLEAR; exactly one active.
REQ-020 IDLE + start + mode 01 -> WRITE; mode 00 -> READ; mode 10 -> CLEAR; mode 11 -> stay IDLE, err pulses next cycle.
REQ-021 On command accept, base_addr and len SHALL be latched; later changes to them during the burst SHALL have no effect.
REQ-022 start while busy SHALL be ignored, with no err.
REQ-023 WRITE: wr_ready high for the whole state; each accepted beat writes wr_data at the current address, then address increments.
REQ-024 Address increment SHALL wrap modulo 2**ADDR_W (address 2**ADDR_W-1 is followed by 0).
REQ-025 WRITE ends on acceptance of beat len+1: next state IDLE, done pulses the same cycle IDLE is entered, wr_ready low in IDLE.
REQ-026 READ: memory read is synchronous with 1-cycle latency; first rd_valid no earlier than 2 cycles after start is sampled.
REQ-027 READ: a one-entry output register SHALL hold rd_data; a new memory read is issued only if the register is empty or is being consumed in the same cycle.
REQ-028 READ: with rd_ready held high, after the first beat one beat SHALL be delivered per cycle with no bubbles.
REQ-029 READ: with rd_ready low, rd_valid and rd_data SHALL hold, and no beat is lost or duplicated.
REQ-030 READ ends when beat len+1 is consumed: done pulses, state returns to IDLE, rd_valid low.
REQ-031 CLEAR: one word per cycle is written to zero, starting at base_addr, for len+1 words with wrap; then done pulses and state returns to IDLE.
REQ-032 CLEAR: wr_ready and rd_valid SHALL stay low.
REQ-033 A write and a read to the same address never coincide, because a single command is active at a time.
REQ-034 After a write burst, a subsequent read of the same address SHALL return the written data.

Reset
REQ-035 RST low SHALL immediately force: state IDLE, busy 0, done 0, err 0, wr_ready 0, rd_valid 0, rd_data 0, internal address/count 0.
REQ-036 Memory array contents SHALL NOT be altered by RST; zeroing is done only by a CLEAR command.
REQ-037 RST asserted mid-burst aborts the burst; writes already accepted remain in memory, with no done pulse.
REQ-038 Operation resumes on the first rising clk edge after RST deasserts.

Verification
REQ-039 Write burst base 0x0010, len 3, data A1,A2,A3,A4 with wr_valid always high -> 4 beats accepted in 4 cycles, done pulses once; read burst base 0x0010, len 3 -> A1,A2,A3,A4.
REQ-040 Wrap-around: write base 0x7FFE, len 3, data 11,22,33,44 -> words 0x7FFE=11, 0x7FFF=22, 0x0000=33, 0x0001=44; a read burst confirms all four.
REQ-041 Backpressure: read len 7 with rd_ready toggling 1,0,0,1,... -> 8 beats delivered in order, rd_data held steady during stalls, done after the 8th handshake.
REQ-042 Clear: fill 0x0100..0x010F with FF, then CLEAR base 0x0104 len 3 -> 0x0104..0x0107 read 00, neighbouring words read FF, done pulses 4 cycles after entering CLEAR.
REQ-043 Command rules: start with mode 11 -> err pulse, busy stays 0; start during a WRITE burst -> ignored, the burst completes normally.
REQ-044 Reset mid-burst: RST low after beat 2 of a len-5 write -> busy 0 and wr_ready 0 immediately, no done; beats 1-2 read back correctly.
